mem_rr_arbiter: RTL and testbench
=================================

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameters WIDTH and ADDR_WIDTH, defaults 32 and 8 from mem_pkg: data width and address width.
REQ-003 clk  input  1: sole clock; all logic rising-edge.
REQ-004 res  input  1: reset, synchronous and active-high.
REQ-005 rq_valid  input  NUM_REQ: per-requester access request.
REQ-006 rq_wr_rd  input  NUM_REQ: 1 is write, 0 is read.
REQ-007 rq_addr  input  NUM_REQ*ADDR_WIDTH: packed; requester i uses [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 rq_wdata  input  NUM_REQ*WIDTH: packed the same way.
REQ-009 rq_ready  output  NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-010 rq_rdata  output  WIDTH: read data, valid while rq_ready pulses for a read.
REQ-011 valid/wr_rd/addr/wdata  output  1/1/ADDR_WIDTH/WIDTH: memory-side request, all registered.
REQ-012 rdata/ready  input  WIDTH/1: memory-side response; ready=1 marks completion.
REQ-013 grant_id  output  $clog2(NUM_REQ): index of the current or last owner.

Function
REQ-014 FSM states: IDLE and BUSY only.
REQ-015 IDLE with any eligible rq_valid: pick the first set bit at or above ptr, wrapping modulo NUM_REQ.
REQ-016 On the pick edge: register the winner's wr_rd/addr/wdata, set valid=1 and grant_id, go to BUSY.
REQ-017 BUSY: valid=1 with wr_rd/addr/wdata stable every cycle until ready=1 is sampled.
REQ-018 Edge sampling ready=1 in BUSY: valid->0; rq_ready[grant_id]->1 for exactly one cycle; ptr->(grant_id+1) mod NUM_REQ; go to IDLE.
REQ-019 Same edge, read: rq_rdata<=rdata. Write: rq_rdata holds its previous value.
REQ-020 In the cycle rq_ready[i]=1, requester i is ineligible; no back-to-back re-grant on a stale rq_valid.
REQ-021 Requester rule: rq_valid and payload stay stable until rq_ready; deassertion is allowed the cycle after. Violations are not checked.
REQ-022 Latency: rq_valid rises in IDLE cycle N -> valid=1 at N+1. Ready in cycle M -> rq_ready at M+1. Minimum 3 cycles per transaction.
REQ-023 ready is ignored in IDLE; at most one rq_ready bit is ever set.
REQ-024 Fairness: a continuously requesting requester is granted within NUM_REQ transactions.

Reset
REQ-025 res=1 at an edge: state IDLE, ptr 0, grant_id 0; valid, wr_rd, addr, wdata, rq_ready, rq_rdata all 0.
REQ-026 Reset during BUSY abandons the access: valid=0 after that edge and no rq_ready is issued.

Configuration
REQ-027 Macro MEM_ARB_TIMEOUT_EN defined: add parameter TIMEOUT (default 64) and output err (1 bit, reset 0).
REQ-028 With the macro, a counter clears on BUSY entry and increments each BUSY cycle without ready.
REQ-029 With the macro, on reaching TIMEOUT: valid->0, rq_ready[grant_id]=1 with err=1 for one cycle, rq_rdata=0, ptr advances, go to IDLE.
REQ-030 With the macro, if ready and timeout coincide, ready wins and err=0.
REQ-031 Without the macro: no counter and no err port; BUSY waits indefinitely.

Structure
REQ-032 mem_pkg holds WIDTH, ADDR_WIDTH, the arb_state_e enum (IDLE, BUSY) and the default TIMEOUT.
REQ-033 Sub-module rr_pick: combinational rotating-priority select; inputs eligible-request vector and ptr; outputs winner index and any.

Verification
REQ-034 NUM_REQ=4: rq_valid=4'b0001 read addr 8'h10, memory ready 2 cycles after valid with rdata 32'hA5A5_0001 -> rq_ready=4'b0001, rq_rdata=32'hA5A5_0001, valid high exactly 3 cycles.
REQ-035 All four requesting from reset, ready every BUSY cycle -> grant order 0,1,2,3,0; each rq_ready one cycle wide.
REQ-036 Requester 2 write addr 8'h3F, wdata 32'hDEAD_BEEF -> memory sees wr_rd=1, addr=8'h3F, wdata=32'hDEAD_BEEF; rq_rdata unchanged.
REQ-037 res=1 on the second BUSY cycle -> valid=0 next edge, no rq_ready, ptr=0, grant_id=0.
REQ-038 Requester 1 held high through its rq_ready cycle with requester 3 pending -> next grant is 3, not 1.
REQ-039 MEM_ARB_TIMEOUT_EN, TIMEOUT=8, ready never asserted -> after 8 BUSY cycles valid=0, rq_ready[g]=1, err=1, rq_rdata=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, arbiter FSM state type and default access timeout
package mem_pkg;
    localparam int WIDTH       = 32;
    localparam int ADDR_WIDTH  = 8;
    localparam int DEF_TIMEOUT = 64;
    typedef enum logic {IDLE, BUSY} arb_state_e;
endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: rotating-priority select of the first set request at or above ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int W = $clog2(N);
    // scan offsets from far to near so the nearest set bit wins
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end
    assign any = |req;
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter of NUM_REQ requesters onto one memory port.
// Define MEM_ARB_TIMEOUT_EN to add a TIMEOUT-cycle access watchdog with an err output.
module mem_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = mem_pkg::WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = mem_pkg::DEF_TIMEOUT
`endif
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [NUM_REQ-1:0]            rq_valid,
    input  logic [NUM_REQ-1:0]            rq_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      rq_wdata,
    output logic [NUM_REQ-1:0]            rq_ready,
    output logic [WIDTH-1:0]              rq_rdata,
    output logic                          valid,
    output logic                          wr_rd,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [WIDTH-1:0]              wdata,
    input  logic [WIDTH-1:0]              rdata,
    input  logic                          ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                          err
`endif
);
    import mem_pkg::*;
    localparam int GW = $clog2(NUM_REQ);

    arb_state_e state, state_n;
    logic [GW-1:0] ptr, win, ptr_nxt;
    logic [NUM_REQ-1:0] elig;
    logic any, done, tmo, fin;

    // a requester is not eligible in its own completion cycle
    assign elig = rq_valid & ~rq_ready;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req(elig),
        .ptr(ptr),
        .idx(win),
        .any(any)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign tmo = state == BUSY && !ready && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (res) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= state == BUSY && !ready ? cnt + 1'b1 : '0;
            err <= tmo;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign done    = state == BUSY && ready;
    assign fin     = done || tmo;
    assign ptr_nxt = grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (any ? BUSY : IDLE) : (fin ? IDLE : BUSY);
    end

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ptr      <= '0;
            grant_id <= '0;
            valid    <= 1'b0;
            wr_rd    <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rq_ready <= '0;
            rq_rdata <= '0;
        end else begin
            rq_ready <= '0;
            if (state == IDLE && any) begin
                grant_id <= win;
                valid    <= 1'b1;
                wr_rd    <= rq_wr_rd[win];
                addr     <= rq_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata    <= rq_wdata[int'(win)*WIDTH +: WIDTH];
            end
            if (fin) begin
                valid              <= 1'b0;
                rq_ready[grant_id] <= 1'b1;
                ptr                <= ptr_nxt;
                if (done && !wr_rd) rq_rdata <= rdata;
                else if (!done) rq_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed scoreboard bench; memory-side and requester-side monitors pop expectations
module tb_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 8;

    typedef struct {int g; logic wr; logic [AW-1:0] a; logic [W-1:0] d;} mreq_t;
    typedef struct {int g; logic [W-1:0] d; logic e;} rsp_t;

    logic clk = 0, res = 1;
    logic [N-1:0] rq_valid = '0, rq_wr_rd = '0, rq_ready, hold = '0;
    logic [N*AW-1:0] rq_addr = '0;
    logic [N*W-1:0] rq_wdata = '0;
    logic [W-1:0] rq_rdata, wdata, rdata = '0, mem_rdata = '0;
    logic valid, wr_rd, ready = 0, mem_en = 1;
    logic [AW-1:0] addr;
    logic [$clog2(N)-1:0] grant_id;
`ifdef MEM_ARB_TIMEOUT_EN
    logic err;
`endif
    int checks = 0, failures = 0, mem_lat = 0, vcnt = 0, vh = 0, last_vh = 0;
    logic vprev = 0;
    logic [N-1:0] rprev = '0;
    mreq_t mq[$];
    rsp_t sq[$];
    mreq_t m;
    rsp_t s;

    mem_rr_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .res(res), .rq_valid(rq_valid), .rq_wr_rd(rq_wr_rd),
        .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_ready(rq_ready),
        .rq_rdata(rq_rdata), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .grant_id(grant_id)
`ifdef MEM_ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // memory model: ready mem_lat cycles after valid rises, rdata = mem_rdata ^ addr
    always @(negedge clk) begin
        ready = valid && mem_en && vcnt == mem_lat;
        rdata = mem_rdata ^ {{(W-AW){1'b0}}, addr};
        vcnt  = valid ? vcnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (valid) vh++;
        else if (vprev) begin
            last_vh = vh;
            vh = 0;
        end
        if (valid && !vprev) begin
            if (mq.size() == 0) chk("mem_unexpected", 32'(valid), 0);
            else begin
                m = mq.pop_front();
                chk("mem_gid", 32'(grant_id), 32'(m.g));
                chk("mem_wr", 32'(wr_rd), 32'(m.wr));
                chk("mem_addr", 32'(addr), 32'(m.a));
                chk("mem_wdata", wdata, m.d);
            end
        end
        if (rq_ready != 0) begin
            chk("rdy_width", 32'(rq_ready & rprev), 0);
            if (sq.size() == 0) chk("rdy_unexpected", 32'(rq_ready), 0);
            else begin
                s = sq.pop_front();
                chk("rdy_onehot", 32'(rq_ready), 32'(1) << s.g);
                chk("rdy_rdata", rq_rdata, s.d);
`ifdef MEM_ARB_TIMEOUT_EN
                chk("rdy_err", 32'(err), 32'(s.e));
`endif
            end
        end
        vprev = valid;
        rprev = rq_ready;
    end

    task automatic expect_txn(input int g, input logic wr, input logic [AW-1:0] a,
                              input logic [W-1:0] d, input logic [W-1:0] rd, input logic e);
        mq.push_back('{g, wr, a, d});
        sq.push_back('{g, rd, e});
    endtask

    task automatic run(input int n, input int budget);
        int got = 0, cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rq_ready != 0) begin
                got++;
                rq_valid = rq_valid & ~(rq_ready & ~hold);
            end
        end
        chk("run_completions", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ready", 32'(rq_ready), 0);
        chk("rst_rdata", rq_rdata, 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wr", 32'(wr_rd), 0);
        res = 0;

        // single read, memory answers 2 cycles after valid
        mem_lat = 2;
        mem_rdata = 32'hA5A5_0011;
        rq_addr[0 +: AW] = 8'h10;
        rq_valid = 4'b0001;
        expect_txn(0, 0, 8'h10, 0, 32'hA5A5_0001, 0);
        run(1, 30);
        @(negedge clk);
        chk("read_valid_cycles", 32'(last_vh), 3);

        // write from requester 2, rq_rdata must hold
        mem_lat = 0;
        mem_rdata = 32'h1234_5678;
        rq_addr[2*AW +: AW] = 8'h3F;
        rq_wdata[2*W +: W] = 32'hDEAD_BEEF;
        rq_wr_rd = 4'b0100;
        rq_valid = 4'b0100;
        expect_txn(2, 1, 8'h3F, 32'hDEAD_BEEF, 32'hA5A5_0001, 0);
        run(1, 30);

        // reset on second BUSY cycle abandons; ptr (was 3) returns to 0
        rq_wr_rd = '0;
        mem_en = 0;
        rq_valid = 4'b0100;
        mq.push_back('{2, 0, 8'h3F, 32'hDEAD_BEEF});
        for (int k = 0; k < 10 && !valid; k++) @(negedge clk);
        chk("abort_busy_seen", 32'(valid), 1);
        @(negedge clk);
        res = 1;
        @(negedge clk);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_gid", 32'(grant_id), 0);
        chk("abort_ready", 32'(rq_ready), 0);
        chk("abort_rdata", rq_rdata, 0);
        res = 0;
        rq_valid = '0;
        mem_en = 1;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        rq_addr[0 +: AW] = 8'h40;
        rq_addr[3*AW +: AW] = 8'h43;
        rq_valid = 4'b1001;
        expect_txn(0, 0, 8'h40, 0, 32'h40, 0);
        expect_txn(3, 0, 8'h43, 0, 32'h43, 0);
        run(2, 40);

        // all four requesting, requester 0 keeps requesting: 0,1,2,3,0
        mem_rdata = 32'h5000_0000;
        for (int i = 0; i < N; i++) rq_addr[i*AW +: AW] = AW'(8'h20 + i);
        hold = 4'b0001;
        rq_valid = 4'b1111;
        expect_txn(0, 0, 8'h20, 0, 32'h5000_0020, 0);
        expect_txn(1, 0, 8'h21, 0, 32'h5000_0021, 0);
        expect_txn(2, 0, 8'h22, 32'hDEAD_BEEF, 32'h5000_0022, 0);
        expect_txn(3, 0, 8'h23, 0, 32'h5000_0023, 0);
        expect_txn(0, 0, 8'h20, 0, 32'h5000_0020, 0);
        run(5, 100);
        rq_valid = '0;
        hold = '0;

        // requester 1 held through its rq_ready cycle; 3 must win next
        mem_rdata = '0;
        rq_addr[1*AW +: AW] = 8'h51;
        rq_addr[3*AW +: AW] = 8'h53;
        hold = 4'b0010;
        rq_valid = 4'b1010;
        expect_txn(1, 0, 8'h51, 0, 32'h51, 0);
        expect_txn(3, 0, 8'h53, 0, 32'h53, 0);
        run(1, 30);
        @(negedge clk);
        rq_valid[1] = 1'b0;
        hold = '0;
        run(1, 30);

`ifdef MEM_ARB_TIMEOUT_EN
        mem_en = 0;
        rq_addr[0 +: AW] = 8'h77;
        rq_valid = 4'b0001;
        expect_txn(0, 0, 8'h77, 0, 32'h0, 1);
        run(1, 40);
        @(negedge clk);
        chk("timeout_valid_cycles", 32'(last_vh), 8);
        mem_en = 1;
`endif

        repeat (5) @(negedge clk);
        chk("mem_queue_drained", 32'(mq.size()), 0);
        chk("rsp_queue_drained", 32'(sq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
